// File: rtl/rx_deserializer_pkg.sv
// Shared constants, parity encoding and right-justify helper for the serial receiver.
package rx_deserializer_pkg;

    localparam int unsigned MAX_BITS_MIN = 5;
    localparam int unsigned MAX_BITS_MAX = 16;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_sense_e;

    // Shift that moves nbits received at the top of a max_bits register down to bit 0.
    function automatic int unsigned rj_shift(input int unsigned max_bits,
                                             input int unsigned nbits);
        return max_bits - nbits;
    endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Saturating frame bit counter with clear and restart-at-one for back-to-back frames.
module rx_bit_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             restart,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Restart beats clear beats increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = CNT_W'(1);
        end else if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < limit)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rx_deserializer.sv
// Serial-to-parallel receiver with per-frame config latch, parity/framing checks and overrun flag.
module rx_deserializer
    import rx_deserializer_pkg::*;
#(
    parameter int unsigned MAX_BITS = 9,
    parameter int unsigned LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                reg_clk,
    input  logic                reg_rst,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic                cfg_msb_first,
    input  logic                cfg_par_en,
    input  logic                cfg_par_odd,
    input  logic                shift,
    input  logic                serial_data_in,
    input  logic                load,
    input  logic                out_ready,
    input  logic                clr_ovr,
    output logic [MAX_BITS-1:0] out_data,
    output logic                out_valid,
    output logic                out_par_err,
    output logic                out_frm_err,
    output logic                overrun
);

    // One extra bit so the parity slot (len + 1) always fits.
    localparam int unsigned CNT_W = LEN_W + 1;

    logic [CNT_W-1:0]    bit_cnt;

    logic [MAX_BITS-1:0] data_q, data_d;
    logic                par_q, par_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                msb_q, msb_d;
    logic                par_en_q, par_en_d;
    par_sense_e          par_odd_q, par_odd_d;

    logic [MAX_BITS-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_par_err_q, out_par_err_d;
    logic                out_frm_err_q, out_frm_err_d;
    logic                overrun_q, overrun_d;

    logic                load_eff_c;
    logic                accept_c;
    logic                new_frame_c;
    logic [LEN_W-1:0]    len_eff_c;
    logic                msb_eff_c;
    logic                par_en_eff_c;
    logic [CNT_W-1:0]    pos_c;
    logic [CNT_W-1:0]    limit_c;
    logic [CNT_W-1:0]    n_q_c;
    logic [CNT_W-1:0]    data_bits_c;
    logic [MAX_BITS-1:0] mask_c;
    logic [MAX_BITS-1:0] word_c;
    logic                par_err_c;

    // Frame control: which config applies to an incoming bit and where it lands.
    always_comb begin
        load_eff_c   = load && (bit_cnt != '0);
        accept_c     = load_eff_c && (!out_valid_q || out_ready);
        new_frame_c  = (bit_cnt == '0) || load_eff_c;
        len_eff_c    = new_frame_c ? cfg_len       : len_q;
        msb_eff_c    = new_frame_c ? cfg_msb_first : msb_q;
        par_en_eff_c = new_frame_c ? cfg_par_en    : par_en_q;
        pos_c        = new_frame_c ? '0            : bit_cnt;
        limit_c      = CNT_W'(len_eff_c) + CNT_W'(par_en_eff_c);
        n_q_c        = CNT_W'(len_q) + CNT_W'(par_en_q);
    end

    // Word assembly from the bits received so far, right-justified, plus parity check.
    always_comb begin
        data_bits_c = (bit_cnt > CNT_W'(len_q)) ? CNT_W'(len_q) : bit_cnt;
        mask_c      = ~({MAX_BITS{1'b1}} << data_bits_c);
        if (msb_q) begin
            word_c = data_q & mask_c;
        end else begin
            word_c = data_q >> rj_shift(MAX_BITS, 32'(data_bits_c));
        end
        par_err_c = par_en_q && ((^word_c) ^ par_q ^ (par_odd_q == PAR_ODD));
    end

    // Next-state for shift/parity registers, config latch and output register.
    always_comb begin
        data_d        = data_q;
        par_d         = par_q;
        len_d         = len_q;
        msb_d         = msb_q;
        par_en_d      = par_en_q;
        par_odd_d     = par_odd_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_par_err_d = out_par_err_q;
        out_frm_err_d = out_frm_err_q;
        overrun_d     = overrun_q;

        if (load_eff_c) begin
            data_d = '0;
            par_d  = 1'b0;
            if (accept_c) begin
                out_data_d    = word_c;
                out_valid_d   = 1'b1;
                out_par_err_d = par_err_c;
                out_frm_err_d = (bit_cnt != n_q_c);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (load_eff_c && !accept_c) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end

        if (shift) begin
            if (new_frame_c) begin
                len_d     = cfg_len;
                msb_d     = cfg_msb_first;
                par_en_d  = cfg_par_en;
                par_odd_d = par_sense_e'(cfg_par_odd);
            end
            if (pos_c < CNT_W'(len_eff_c)) begin
                if (msb_eff_c) begin
                    data_d = {data_d[MAX_BITS-2:0], serial_data_in};
                end else begin
                    data_d = {serial_data_in, data_d[MAX_BITS-1:1]};
                end
            end else if ((pos_c == CNT_W'(len_eff_c)) && par_en_eff_c) begin
                par_d = serial_data_in;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            data_q        <= '0;
            par_q         <= 1'b0;
            len_q         <= '0;
            msb_q         <= 1'b0;
            par_en_q      <= 1'b0;
            par_odd_q     <= PAR_EVEN;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_par_err_q <= 1'b0;
            out_frm_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            data_q        <= data_d;
            par_q         <= par_d;
            len_q         <= len_d;
            msb_q         <= msb_d;
            par_en_q      <= par_en_d;
            par_odd_q     <= par_odd_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_par_err_q <= out_par_err_d;
            out_frm_err_q <= out_frm_err_d;
            overrun_q     <= overrun_d;
        end
    end

    rx_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (reg_clk),
        .rst     (reg_rst),
        .clr     (load_eff_c && !shift),
        .restart (load_eff_c && shift),
        .inc     (shift),
        .limit   (limit_c),
        .cnt     (bit_cnt)
    );

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_par_err = out_par_err_q;
    assign out_frm_err = out_frm_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_rx_deserializer.sv
// Self-checking bench: frame vectors, directed corner sequences, and random traffic vs a frame model.
module tb_rx_deserializer;

    localparam int unsigned MAX_BITS = 9;
    localparam int unsigned LEN_W    = $clog2(MAX_BITS + 1);

    logic                reg_clk = 1'b0;
    logic                reg_rst = 1'b0;
    logic [LEN_W-1:0]    cfg_len = LEN_W'(8);
    logic                cfg_msb_first = 1'b0;
    logic                cfg_par_en = 1'b0;
    logic                cfg_par_odd = 1'b0;
    logic                shift = 1'b0;
    logic                serial_data_in = 1'b0;
    logic                load = 1'b0;
    logic                out_ready = 1'b0;
    logic                clr_ovr = 1'b0;
    logic [MAX_BITS-1:0] out_data;
    logic                out_valid;
    logic                out_par_err;
    logic                out_frm_err;
    logic                overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: bits of the current frame as a plain list.
    logic        m_bits [0:16];
    int          m_cnt = 0;
    int          m_len = 0;
    int          m_pe  = 0;
    logic        m_msb = 1'b0;
    logic        m_odd = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_valid = 1'b0;
    logic        m_perr = 1'b0;
    logic        m_ferr = 1'b0;
    logic        m_ovr = 1'b0;

    typedef struct {
        string       name;
        logic        msb;
        int          len;
        logic        pe;
        logic        odd;
        int          nbits;
        logic [15:0] bits;
        logic [15:0] exp_data;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs [6];

    rx_deserializer #(
        .MAX_BITS (MAX_BITS),
        .LEN_W    (LEN_W)
    ) dut (
        .reg_clk        (reg_clk),
        .reg_rst        (reg_rst),
        .cfg_len        (cfg_len),
        .cfg_msb_first  (cfg_msb_first),
        .cfg_par_en     (cfg_par_en),
        .cfg_par_odd    (cfg_par_odd),
        .shift          (shift),
        .serial_data_in (serial_data_in),
        .load           (load),
        .out_ready      (out_ready),
        .clr_ovr        (clr_ovr),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_par_err    (out_par_err),
        .out_frm_err    (out_frm_err),
        .overrun        (overrun)
    );

    always #5 reg_clk = ~reg_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: word is built from the list of received bits at load time.
    task automatic model_step();
        int          k;
        logic [31:0] w;
        logic        par;
        logic        perr;
        logic        dropped;
        if (reg_rst) begin
            m_cnt = 0; m_data = '0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            return;
        end
        dropped = 1'b0;
        if (load && (m_cnt != 0)) begin
            k = (m_cnt < m_len) ? m_cnt : m_len;
            w = '0;
            for (int i = 0; i < k; i++) begin
                if (m_bits[i]) w = w | (m_msb ? (32'd1 << (k - 1 - i)) : (32'd1 << i));
            end
            par  = ((m_pe != 0) && (m_cnt > m_len)) ? m_bits[m_len] : 1'b0;
            perr = (m_pe != 0) ? ((^w) ^ par ^ m_odd) : 1'b0;
            if (!m_valid || out_ready) begin
                m_data  = w;
                m_valid = 1'b1;
                m_perr  = perr;
                m_ferr  = (m_cnt != m_len + m_pe);
            end else begin
                dropped = 1'b1;
            end
            m_cnt = 0;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (dropped) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
        if (shift) begin
            if (m_cnt == 0) begin
                m_len = int'(cfg_len);
                m_pe  = cfg_par_en ? 1 : 0;
                m_msb = cfg_msb_first;
                m_odd = cfg_par_odd;
            end
            if (m_cnt < m_len + m_pe) begin
                m_bits[m_cnt] = serial_data_in;
                m_cnt++;
            end
        end
    endtask

    // One clock: inputs already driven; returns at the following falling edge with pulses cleared.
    task automatic cycle();
        @(posedge reg_clk);
        model_step();
        @(negedge reg_clk);
        shift = 1'b0; load = 1'b0; clr_ovr = 1'b0; reg_rst = 1'b0;
    endtask

    task automatic send_frame(input logic msb, input int len, input logic pe, input logic odd,
                              input int nbits, input logic [15:0] bits);
        cfg_msb_first = msb; cfg_len = LEN_W'(len); cfg_par_en = pe; cfg_par_odd = odd;
        for (int i = 0; i < nbits; i++) begin
            shift = 1'b1;
            serial_data_in = bits[i];
            cycle();
        end
    endtask

    task automatic do_load();
        load = 1'b1;
        cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  32'(out_data), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_perr"},  32'(out_par_err), 32'd0);
        chk({tag, "_ferr"},  32'(out_frm_err), 32'd0);
        chk({tag, "_ovr"},   32'(overrun), 32'd0);
    endtask

    initial begin
        // bits[i] is the i-th bit on the wire
        vecs[0] = '{"lsb8_aa",      1'b0, 8, 1'b0, 1'b0, 8,  16'h00AA, 16'h00AA, 1'b0, 1'b0};
        vecs[1] = '{"msb7_even_ok", 1'b1, 7, 1'b1, 1'b0, 8,  16'h0065, 16'h0053, 1'b0, 1'b0};
        vecs[2] = '{"msb7_even_bad",1'b1, 7, 1'b1, 1'b0, 8,  16'h00E5, 16'h0053, 1'b1, 1'b0};
        vecs[3] = '{"msb8_short",   1'b1, 8, 1'b0, 1'b0, 5,  16'h0013, 16'h0019, 1'b0, 1'b1};
        vecs[4] = '{"lsb8_long",    1'b0, 8, 1'b0, 1'b0, 10, 16'h03A5, 16'h00A5, 1'b0, 1'b0};
        vecs[5] = '{"lsb9_odd_ok",  1'b0, 9, 1'b1, 1'b1, 10, 16'h01FF, 16'h01FF, 1'b0, 1'b0};

        // Reset with other inputs active: reset must win.
        reg_rst = 1'b1; shift = 1'b1; load = 1'b1; serial_data_in = 1'b1;
        cycle();
        reg_rst = 1'b1;
        cycle();
        chk_all_zero("reset");

        // Table-driven frames, consumer always ready.
        out_ready = 1'b1;
        foreach (vecs[v]) begin
            send_frame(vecs[v].msb, vecs[v].len, vecs[v].pe, vecs[v].odd, vecs[v].nbits, vecs[v].bits);
            do_load();
            chk({vecs[v].name, "_data"},  32'(out_data), 32'(vecs[v].exp_data));
            chk({vecs[v].name, "_valid"}, 32'(out_valid), 32'd1);
            chk({vecs[v].name, "_perr"},  32'(out_par_err), 32'(vecs[v].exp_perr));
            chk({vecs[v].name, "_ferr"},  32'(out_frm_err), 32'(vecs[v].exp_ferr));
        end

        // Len 5 LSB-first even parity with a wrong parity bit.
        send_frame(1'b0, 5, 1'b1, 1'b0, 6, 16'h0015);
        do_load();
        chk("lsb5_even_bad_data", 32'(out_data), 32'h15);
        chk("lsb5_even_bad_perr", 32'(out_par_err), 32'd1);

        // Ready without load drops valid and holds data.
        cycle();
        chk("ready_clears_valid", 32'(out_valid), 32'd0);
        chk("ready_holds_data",   32'(out_data), 32'h15);

        // Overrun: second word dropped while consumer stalls.
        out_ready = 1'b0;
        send_frame(1'b0, 9, 1'b0, 1'b0, 9, 16'h0123);
        do_load();
        chk("ovr_a_data", 32'(out_data), 32'h123);
        send_frame(1'b0, 9, 1'b0, 1'b0, 9, 16'h00F0);
        do_load();
        chk("ovr_b_data",  32'(out_data), 32'h123);
        chk("ovr_b_valid", 32'(out_valid), 32'd1);
        chk("ovr_b_flag",  32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        cycle();
        chk("ovr_cleared", 32'(overrun), 32'd0);
        do_load();
        chk("empty_load_ovr",  32'(overrun), 32'd0);
        chk("empty_load_data", 32'(out_data), 32'h123);
        send_frame(1'b0, 9, 1'b0, 1'b0, 9, 16'h0055);
        clr_ovr = 1'b1;
        do_load();
        chk("ovr_beats_clr", 32'(overrun), 32'd1);
        out_ready = 1'b1; clr_ovr = 1'b1;
        cycle();

        // Config changed after first bit is ignored for the rest of the frame.
        send_frame(1'b0, 6, 1'b1, 1'b0, 1, 16'h0001);
        send_frame(1'b1, 9, 1'b0, 1'b1, 6, 16'h0025);
        do_load();
        chk("cfg_latch_data", 32'(out_data), 32'h0B);
        chk("cfg_latch_ferr", 32'(out_frm_err), 32'd0);
        chk("cfg_latch_perr", 32'(out_par_err), 32'd0);

        // Load and shift together: old frame out, new frame starts with that bit.
        send_frame(1'b0, 8, 1'b0, 1'b0, 8, 16'h005A);
        cfg_msb_first = 1'b1; cfg_len = LEN_W'(8);
        load = 1'b1; shift = 1'b1; serial_data_in = 1'b1;
        cycle();
        chk("ls_prev_data", 32'(out_data), 32'h5A);
        chk("ls_prev_ferr", 32'(out_frm_err), 32'd0);
        send_frame(1'b1, 8, 1'b0, 1'b0, 7, 16'h0066);
        do_load();
        chk("ls_next_data", 32'(out_data), 32'hB3);
        chk("ls_next_ferr", 32'(out_frm_err), 32'd0);

        // Reset mid-frame discards partial bits.
        send_frame(1'b0, 8, 1'b0, 1'b0, 4, 16'h000F);
        reg_rst = 1'b1;
        cycle();
        chk_all_zero("midrst");
        send_frame(1'b0, 8, 1'b0, 1'b0, 8, 16'h003C);
        do_load();
        chk("post_rst_data", 32'(out_data), 32'h3C);
        chk("post_rst_ferr", 32'(out_frm_err), 32'd0);
        chk("post_rst_perr", 32'(out_par_err), 32'd0);

        // Random traffic against the frame model.
        reg_rst = 1'b1;
        cycle();
        for (int c = 0; c < 4000; c++) begin
            reg_rst        = ($urandom_range(0, 299) == 0);
            cfg_len        = LEN_W'($urandom_range(5, MAX_BITS));
            cfg_msb_first  = 1'($urandom_range(0, 1));
            cfg_par_en     = 1'($urandom_range(0, 1));
            cfg_par_odd    = 1'($urandom_range(0, 1));
            shift          = ($urandom_range(0, 9) < 7);
            serial_data_in = 1'($urandom_range(0, 1));
            load           = ($urandom_range(0, 9) == 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            clr_ovr        = ($urandom_range(0, 15) == 0);
            cycle();
            chk("rnd_data",  32'(out_data), m_data);
            chk("rnd_valid", 32'(out_valid), 32'(m_valid));
            chk("rnd_perr",  32'(out_par_err), 32'(m_perr));
            chk("rnd_ferr",  32'(out_frm_err), 32'(m_ferr));
            chk("rnd_ovr",   32'(overrun), 32'(m_ovr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
